// File: rtl/swt_debounce.sv
// ---------------------------------------------------------------------------
// swt_debounce
//
// Conditioning stage between the raw board switches and the 8-switch LED
// logic. Each switch bit goes through:
//   1. A two-flop synchronizer. The raw pins are asynchronous to clk and can
//      bounce, so only the second stage is used downstream.
//   2. A stability counter. The debounced level flips only after the
//      synchronized input has differed from it for STABLE_CYCLES consecutive
//      cycles. Any return to the current level restarts the whole count.
//   3. Registered edge detection. This gives one-cycle rise/fall pulses and a
//      combined "something changed" flag for later sequential consumers.
//
// Every output comes from a flop, so there is no combinational path from
// swt_raw to any output.
//
// Ports:
//   clk       in   1      system clock; all state changes on the rising edge
//   rst       in   1      synchronous, active-high reset
//   swt_raw   in   WIDTH  raw switch pins (asynchronous, may bounce)
//   swt       out  WIDTH  debounced switch levels (feeds the LED logic)
//   swt_rise  out  WIDTH  one-cycle pulse per bit on a debounced 0->1
//   swt_fall  out  WIDTH  one-cycle pulse per bit on a debounced 1->0
//   swt_chg   out  1      OR of all rise/fall pulses, same cycle as them
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  cycles a difference must persist before swt flips (>= 2)
//   CNT_W          counter width; 2**CNT_W must exceed STABLE_CYCLES-1
// ---------------------------------------------------------------------------
module swt_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] swt_raw,
    output logic [WIDTH-1:0] swt,
    output logic [WIDTH-1:0] swt_rise,
    output logic [WIDTH-1:0] swt_fall,
    output logic             swt_chg
);

    // Per-bit state. IDLE means the synchronized input agrees with the
    // debounced level. PENDING means they differ and the counter is running.
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    // Terminal count. Reaching it while still PENDING flips the output bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Two-flop synchronizer, with nothing between the stages.
    // Reset clears both stages so that a switch held high during reset is
    // treated as a fresh change afterwards. It then has to pass the full
    // stability count before it shows up on swt.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= swt_raw;
            sync2 <= sync1;
        end
    end

    // Decode the per-bit state and find the bits that flip on this edge.
    // The state is simply "synchronized input differs from debounced level".
    // A flip occurs when a bit is PENDING and its counter is at terminal
    // count. The new level of a flipping bit is sync2, which tells us the
    // pulse direction.
    always_comb begin
        state     = sync2 ^ swt;
        flip      = '0;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i]      = (state[i] == ST_PENDING) && (cnt[i] == CNT_LAST);
            rise_next[i] = flip[i] & sync2[i];
            fall_next[i] = flip[i] & ~sync2[i];
        end
    end

    // Stability counters, one per bit.
    // - IDLE clears the counter. A bounce back to the current level therefore
    //   throws away all progress.
    // - PENDING counts up until terminal count, then wraps to 0 on the same
    //   edge where the output flips. That makes the next cycle IDLE again.
    // The counter never goes past CNT_LAST, so it cannot wrap through zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        cnt[i] <= '0;
                    end
                    ST_PENDING: begin
                        if (flip[i]) begin
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    // Debounced levels and event pulses.
    // A flipping bit toggles. Since flips only happen while sync2 differs from
    // swt, toggling is the same as loading sync2. The pulses are registered
    // from the same flip decode, so they line up exactly with the swt change.
    // They fall back to 0 on the next edge because flip cannot fire two
    // cycles in a row. A bit cannot be both rising and falling at once,
    // because rise_next and fall_next use opposite polarities of sync2.
    always_ff @(posedge clk) begin
        if (rst) begin
            swt      <= '0;
            swt_rise <= '0;
            swt_fall <= '0;
            swt_chg  <= 1'b0;
        end else begin
            swt      <= swt ^ flip;
            swt_rise <= rise_next;
            swt_fall <= fall_next;
            swt_chg  <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_swt_debounce.sv
// ---------------------------------------------------------------------------
// tb_swt_debounce
//
// Directed, self-checking bench for swt_debounce with STABLE_CYCLES=4 and
// CNT_W=3. With these settings a raw change that is stable before edge E1
// appears on swt, together with its pulse, at edge E6.
//
// Inputs are driven #1 after a rising edge. Outputs are sampled at that same
// point, so each check sees the result of the edge that just happened.
// ---------------------------------------------------------------------------
module tb_swt_debounce;

    localparam int WIDTH         = 8;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] swt_raw;
    logic [WIDTH-1:0] swt;
    logic [WIDTH-1:0] swt_rise;
    logic [WIDTH-1:0] swt_fall;
    logic             swt_chg;

    int checkCount;
    int errorCount;

    swt_debounce #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .swt_raw (swt_raw),
        .swt     (swt),
        .swt_rise(swt_rise),
        .swt_fall(swt_fall),
        .swt_chg (swt_chg)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report when it differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check the level and all three pulse outputs together.
    task automatic checkAll(input string tag, input logic [7:0] expSwt, input logic [7:0] expRise,
                            input logic [7:0] expFall, input logic expChg);
        checkOutput({tag, ".swt"},  32'(swt),      32'(expSwt));
        checkOutput({tag, ".rise"}, 32'(swt_rise), 32'(expRise));
        checkOutput({tag, ".fall"}, 32'(swt_fall), 32'(expFall));
        checkOutput({tag, ".chg"},  32'(swt_chg),  32'(expChg));
    endtask

    task automatic applyStimulus(input logic [7:0] raw, input logic rstVal);
        swt_raw = raw;
        rst     = rstVal;
    endtask

    // Advance one rising edge and settle a little past it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Wait long enough for any change to finish propagating.
    task automatic settle(input int n);
        for (int k = 0; k < n; k++) stepClock();
    endtask

    // Apply a new raw value. Expect no change through E5, then the flip and
    // pulses at E6, then quiet pulses at E7.
    task automatic expectFlip(input string tag, input logic [7:0] fromVal, input logic [7:0] toVal);
        applyStimulus(toVal, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            stepClock();
            checkAll($sformatf("%s.E%0d", tag, e), fromVal, 8'h00, 8'h00, 1'b0);
        end
        stepClock();
        checkAll({tag, ".E6"}, toVal, toVal & ~fromVal, fromVal & ~toVal, (toVal != fromVal));
        stepClock();
        checkAll({tag, ".E7"}, toVal, 8'h00, 8'h00, 1'b0);
    endtask

    logic [7:0] sweepVal;

    initial begin
        checkCount = 0;
        errorCount = 0;
        applyStimulus(8'hFF, 1'b1);

        // Reset with every switch high: all outputs must stay at zero.
        for (int c = 0; c < 3; c++) begin
            stepClock();
            checkAll($sformatf("reset%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Clean rise on bit 0, applied as reset drops.
        expectFlip("rise0", 8'h00, 8'h01);

        // Return to all-zero before the bounce test.
        applyStimulus(8'h00, 1'b0);
        settle(8);
        checkOutput("clear.swt", 32'(swt), 32'h00);

        // Bounce on bit 3: high pulses of 2 cycles must never reach swt.
        for (int b = 0; b < 4; b++) begin
            applyStimulus((b % 2 == 0) ? 8'h08 : 8'h00, 1'b0);
            for (int c = 0; c < 2; c++) begin
                stepClock();
                checkAll($sformatf("bounce%0d.%0d", b, c), 8'h00, 8'h00, 8'h00, 1'b0);
            end
        end
        applyStimulus(8'h00, 1'b0);
        for (int c = 0; c < 6; c++) begin
            stepClock();
            checkAll($sformatf("bounceHold%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Once bit 3 holds steadily high, it comes through.
        expectFlip("steady3", 8'h00, 8'h08);

        // Multi-bit rise and fall happening together.
        applyStimulus(8'h0F, 1'b0);
        settle(8);
        checkOutput("pre.multi.swt", 32'(swt), 32'h0F);
        expectFlip("multi", 8'h0F, 8'hF0);

        // Reset arriving partway through a count.
        applyStimulus(8'h00, 1'b0);
        settle(8);
        checkOutput("pre.midrst.swt", 32'(swt), 32'h00);
        applyStimulus(8'h80, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            stepClock();
            checkAll($sformatf("midrst.E%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(8'h80, 1'b1);
        stepClock();
        checkAll("midrst.E4", 8'h00, 8'h00, 8'h00, 1'b0);
        expectFlip("postrst", 8'h00, 8'h80);

        // End-to-end sweep over even values, 10 cycles each. After each value
        // settles, check swt and the LED mapping derived from it.
        for (int v = 0; v < 256; v += 2) begin
            sweepVal = 8'(v);
            applyStimulus(sweepVal, 1'b0);
            settle(10);
            checkOutput($sformatf("sweep%0d.swt", v), 32'(swt), 32'(sweepVal));
            checkOutput($sformatf("sweep%0d.led", v), 32'({swt[7:4], ~swt[0]}),
                        32'({sweepVal[7:4], ~sweepVal[0]}));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
